// File: rtl/if_id_buf_if.sv
// if_id_buf_if: fetch-side and decode-side signals of the IF/ID elastic buffer
interface if_id_buf_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic [XLEN-1:0] in_pc;
    logic [XLEN-1:0] in_pc_n;
    logic [XLEN-1:0] in_inst;
    logic            flush;
    logic            pc_en;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_pc_n;
    logic [XLEN-1:0] out_inst;

    modport master (
        output in_valid, in_pc, in_pc_n, in_inst, flush, out_ready,
        input  pc_en, out_valid, out_pc, out_pc_n, out_inst
    );

    modport slave (
        input  in_valid, in_pc, in_pc_n, in_inst, flush, out_ready,
        output pc_en, out_valid, out_pc, out_pc_n, out_inst
    );
endinterface

// File: rtl/if_id_buf.sv
// if_id_buf: 2-entry elastic buffer between fetch and decode with flush and stall counter
module if_id_buf #(
    parameter int              XLEN  = 32,
    parameter logic [XLEN-1:0] NOP   = 32'h00000013,
    parameter int              CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    if_id_buf_if.slave       bus,
    output logic [CNT_W-1:0] stall_cnt
);
    logic [XLEN-1:0] pc_q   [2];
    logic [XLEN-1:0] pc_n_q [2];
    logic [XLEN-1:0] inst_q [2];
    logic            head;
    logic [1:0]      count;
    logic            enq;
    logic            deq;
    logic            tail;

    // pc_en depends only on registered count, keeping out_ready off the PC enable path
    assign bus.pc_en     = count != 2'd2;
    assign bus.out_valid = count != 2'd0;
    assign enq           = bus.in_valid & bus.pc_en & ~bus.flush;
    assign deq           = bus.out_valid & bus.out_ready & ~bus.flush;
    assign tail          = head ^ count[0];
    assign bus.out_pc    = bus.out_valid ? pc_q[head]   : '0;
    assign bus.out_pc_n  = bus.out_valid ? pc_n_q[head] : '0;
    assign bus.out_inst  = bus.out_valid ? inst_q[head] : NOP;

    always_ff @(posedge clk) begin
        if (rst) begin
            head      <= 1'b0;
            count     <= 2'd0;
            stall_cnt <= '0;
            for (int i = 0; i < 2; i++) begin
                pc_q[i]   <= '0;
                pc_n_q[i] <= '0;
                inst_q[i] <= '0;
            end
        end else begin
            if (bus.in_valid & ~bus.pc_en & ~bus.flush & ~&stall_cnt)
                stall_cnt <= stall_cnt + 1'b1;
            if (bus.flush) begin
                head  <= 1'b0;
                count <= 2'd0;
            end else begin
                if (enq) begin
                    pc_q[tail]   <= bus.in_pc;
                    pc_n_q[tail] <= bus.in_pc_n;
                    inst_q[tail] <= bus.in_inst;
                end
                if (deq)
                    head <= ~head;
                count <= count + {1'b0, enq} - {1'b0, deq};
            end
        end
    end
endmodule
